encoder: RTL and testbench
==========================

# encoder

Registered 4-bit-code to 7-segment glyph encoder for the parking-lot display path. It drives one HEX digit on the board. The display block instantiates six of these, one per digit (HEX0..HEX5). Codes 0–9 are decimal digits. Codes A–F carry the status glyphs used by the display block: "FULL" lettering, dash and blank.

## Interface
Parameters:
- ACTIVE_LOW, default 1: segment polarity. 1 means a lit segment is driven 0, matching the board.
- BLINK_DIV, default 25_000_000: half-period of the blink, in clk cycles. Used only when ENCODER_BLINK_EN is defined.

Ports:
- clk  in  1  system clock; one clock domain only.
- rst_n  in  1  asynchronous, active-low reset.
- dataIn  in  4  code to display.
- blank  in  1  forces all segments dark when high.
- blink  in  1  blink request. Present only with ENCODER_BLINK_EN.
- disCode  out  7  segment drive. Bit 0 = a, bit 1 = b, bit 2 = c, bit 3 = d, bit 4 = e, bit 5 = f, bit 6 = g.

## Operation
Glyph map, stated as lit segments:
- 0 = abcdef
- 1 = bc
- 2 = abdeg
- 3 = abcdg
- 4 = bcfg
- 5 = acdfg
- 6 = acdefg
- 7 = abc
- 8 = abcdefg
- 9 = abcdfg
- A = "F" = aefg
- B = "U" = bcdef
- C = "L" = def
- D = dash = g
- E = blank = none
- F = blank = none

Output levels:
- With ACTIVE_LOW=1, lit = 0.
- Reference values for ACTIVE_LOW=1:
  - 0 → 7'b1000000
  - 3 → 7'b0110000
  - A → 7'b0001110
  - B → 7'b1000001
  - C → 7'b1000111
  - D → 7'b0111111
  - E → 7'b1111111
- With ACTIVE_LOW=0, every output is the bitwise inverse.

Other rules:
- blank=1 overrides dataIn; the output is the all-dark pattern.
- The decode is total over all 16 codes. There are no X or default-latch paths.

## Timing
- disCode is registered, so latency is 1 clk. The output reflects dataIn/blank sampled at the previous rising edge.
- On rst_n low: disCode goes immediately, asynchronously, to all-dark. That is 7'h7F for ACTIVE_LOW=1 and 7'h00 for ACTIVE_LOW=0.
- First real glyph appears after the first rising edge following rst_n release.
- Reset asserted mid-operation: the output goes dark at once, and any blink counter and phase clear.
- Input changes every cycle are honoured cycle for cycle; there is no debounce or hold.

## Configuration
Macro: ENCODER_BLINK_EN.

Defined:
- Adds the blink port.
- Adds a free-running counter of width $clog2(BLINK_DIV) and a phase flip-flop. Both reset to 0; phase 0 means visible.
- The phase toggles when the counter reaches BLINK_DIV-1, and the counter then wraps to 0.
- While blink=1 and phase=1, the output is all-dark.
- blink=0 shows the glyph regardless of phase. The counter keeps running.
- Precedence: blank, then blink-dark, then glyph.

Not defined:
- No blink port, counter or phase logic.
- Behaviour is exactly as in the Operation section.

## Structure
- Package encoder_pkg holds:
  - typedef seg7_t, as logic [6:0];
  - localparam glyph constants in active-high form: SEG_0 … SEG_9, SEG_F, SEG_U, SEG_L, SEG_DASH, SEG_BLANK;
  - code constants CODE_F=4'hA, CODE_U=4'hB, CODE_L=4'hC, CODE_DASH=4'hD, CODE_BLANK=4'hE.
- Polarity inversion is applied once, at the register input.
- One natural sub-module, blink_timer: the counter plus phase flip-flop, instantiated only under ENCODER_BLINK_EN.

## Test plan
- Reset: hold rst_n=0 with dataIn=8 → disCode=7'h7F with no clock edge. Release, one edge → 7'b0000000.
- Sweep dataIn 0..F, one per cycle → each output matches the glyph map exactly one cycle later; E and F → 7'h7F.
- "FULL" sequence: A, B, C, C → 7'b0001110, 7'b1000001, 7'b1000111, 7'b1000111.
- blank=1 with dataIn=3 → 7'h7F next cycle; drop blank → 7'b0110000 next cycle. Also run with ACTIVE_LOW=0 → outputs inverted.
- Mid-run reset: dataIn=D steady, pulse rst_n low between edges → output goes to 7'h7F immediately, and 7'b0111111 returns one edge after release.
- ENCODER_BLINK_EN, BLINK_DIV=4: blink=1, dataIn=1 → 7'b1111001 for 4 cycles, then 7'h7F for 4 cycles, repeating. blink=0 → steady 7'b1111001.

Source files
------------

// File: rtl/encoder_pkg.sv
// encoder_pkg: shared types and constants for the 7-segment glyph encoder.
//   seg7_t     : segment vector, bit0=a .. bit6=g
//   SEG_*      : glyphs in active-high form (1 = lit)
//   CODE_*     : input codes for the status glyphs
//   glyph()    : total decode of a 4-bit code to an active-high glyph
package encoder_pkg;

  typedef logic [6:0] seg7_t;

  //                              gfedcba
  localparam seg7_t SEG_0     = 7'b0111111;
  localparam seg7_t SEG_1     = 7'b0000110;
  localparam seg7_t SEG_2     = 7'b1011011;
  localparam seg7_t SEG_3     = 7'b1001111;
  localparam seg7_t SEG_4     = 7'b1100110;
  localparam seg7_t SEG_5     = 7'b1101101;
  localparam seg7_t SEG_6     = 7'b1111101;
  localparam seg7_t SEG_7     = 7'b0000111;
  localparam seg7_t SEG_8     = 7'b1111111;
  localparam seg7_t SEG_9     = 7'b1101111;
  localparam seg7_t SEG_F     = 7'b1110001;
  localparam seg7_t SEG_U     = 7'b0111110;
  localparam seg7_t SEG_L     = 7'b0111000;
  localparam seg7_t SEG_DASH  = 7'b1000000;
  localparam seg7_t SEG_BLANK = 7'b0000000;

  localparam logic [3:0] CODE_F     = 4'hA;
  localparam logic [3:0] CODE_U     = 4'hB;
  localparam logic [3:0] CODE_L     = 4'hC;
  localparam logic [3:0] CODE_DASH  = 4'hD;
  localparam logic [3:0] CODE_BLANK = 4'hE;

  // Codes E and F both land on the default arm: blank.
  function automatic seg7_t glyph(input logic [3:0] code);
    case (code)
      4'h0:      return SEG_0;
      4'h1:      return SEG_1;
      4'h2:      return SEG_2;
      4'h3:      return SEG_3;
      4'h4:      return SEG_4;
      4'h5:      return SEG_5;
      4'h6:      return SEG_6;
      4'h7:      return SEG_7;
      4'h8:      return SEG_8;
      4'h9:      return SEG_9;
      CODE_F:    return SEG_F;
      CODE_U:    return SEG_U;
      CODE_L:    return SEG_L;
      CODE_DASH: return SEG_DASH;
      default:   return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/encoder_if.sv
// encoder_if: display-side bundle for one digit.
//   dataIn  : 4-bit code to display
//   blank   : force all segments dark
//   blink   : blink request (only with ENCODER_BLINK_EN)
//   disCode : 7-bit segment drive, bit0=a .. bit6=g
// Modports: master drives codes and reads segments; slave is the encoder.
interface encoder_if;
  import encoder_pkg::*;

  logic [3:0] dataIn;
  logic       blank;
`ifdef ENCODER_BLINK_EN
  logic       blink;
`endif
  seg7_t      disCode;

`ifdef ENCODER_BLINK_EN
  modport master (output dataIn, blank, blink, input disCode);
  modport slave  (input dataIn, blank, blink, output disCode);
`else
  modport master (output dataIn, blank, input disCode);
  modport slave  (input dataIn, blank, output disCode);
`endif

endinterface

// File: rtl/encoder_blink_timer.sv
// blink_timer: free-running divider plus phase flop for the digit blink.
//   clk, rst_n : clock, async active-low reset (clears counter and phase)
//   o_phase    : 0 = visible half, 1 = dark half; toggles every DIV cycles
module blink_timer #(
  parameter int DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_phase
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == CW'(DIV - 1)) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign o_phase = r_phase;

endmodule

// File: rtl/encoder.sv
// encoder: registered 4-bit code to 7-segment glyph, one HEX digit.
//   clk, rst_n : clock, async active-low reset (output dark at once)
//   bus        : encoder_if.slave (dataIn, blank, [blink], disCode)
// Parameters:
//   ACTIVE_LOW : 1 -> lit segment driven 0
//   BLINK_DIV  : blink half-period in clk cycles
// Optional feature macro: ENCODER_BLINK_EN adds blink input and timer.
// Precedence: blank, then blink-dark, then glyph. Latency 1 clk.
module encoder
  import encoder_pkg::*;
#(
  parameter int ACTIVE_LOW = 1,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic      clk,
  input  logic      rst_n,
  encoder_if.slave  bus
);

  // All-dark level at the pins, used as the reset value.
  localparam seg7_t DARK = (ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;

  if (BLINK_DIV < 2) begin : g_div_chk
    $error("encoder: BLINK_DIV must be >= 2");
  end

  logic  w_dark;
  seg7_t w_seg;
  seg7_t r_dis;

`ifdef ENCODER_BLINK_EN
  logic w_phase;

  blink_timer #(.DIV(BLINK_DIV)) u_blink (
    .clk     (clk),
    .rst_n   (rst_n),
    .o_phase (w_phase)
  );

  assign w_dark = bus.blank | (bus.blink & w_phase);
`else
  assign w_dark = bus.blank;
`endif

  assign w_seg = w_dark ? SEG_BLANK : glyph(bus.dataIn);

  // Polarity is applied once, right at the register input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dis <= DARK;
    else        r_dis <= (ACTIVE_LOW != 0) ? ~w_seg : w_seg;
  end

  assign bus.disCode = r_dis;

endmodule

// File: tb/tb_encoder.sv
// tb_encoder: directed + random checks of encoder, both polarities side by side.
// Reference model builds each glyph from its lit-segment letters.
module tb_encoder;

  logic clk;
  logic rst_n;

  encoder_if u_if_lo ();
  encoder_if u_if_hi ();

  encoder #(.ACTIVE_LOW(1), .BLINK_DIV(4)) dut_lo (.clk(clk), .rst_n(rst_n), .bus(u_if_lo));
  encoder #(.ACTIVE_LOW(0), .BLINK_DIV(4)) dut_hi (.clk(clk), .rst_n(rst_n), .bus(u_if_hi));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  string LIT [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                      "abcdefg", "abcdfg", "aefg", "bcdef", "def", "g", "", ""};

  function automatic logic [6:0] model(input int code, input bit dark, input bit al);
    logic [6:0] v;
    string s;
    v = '0;
    s = dark ? "" : LIT[code];
    for (int i = 0; i < s.len(); i++) v[int'(s[i]) - 97] = 1'b1;
    return al ? ~v : v;
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] d, input logic b);
    u_if_lo.dataIn = d; u_if_hi.dataIn = d;
    u_if_lo.blank  = b; u_if_hi.blank  = b;
  endtask

`ifdef ENCODER_BLINK_EN
  task automatic drive_blink(input logic bl);
    u_if_lo.blink = bl; u_if_hi.blink = bl;
  endtask
`endif

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [6:0] full_exp [4];
  logic [3:0] full_code [4];
  logic [3:0] rd;
  logic       rb;

  initial begin
    full_code = '{4'hA, 4'hB, 4'hC, 4'hC};
    full_exp  = '{7'b0001110, 7'b1000001, 7'b1000111, 7'b1000111};

    rst_n = 1'b1;
    drive(4'h8, 1'b0);
`ifdef ENCODER_BLINK_EN
    drive_blink(1'b0);
`endif
    #1 rst_n = 1'b0;
    #2;
    check("reset_lo", u_if_lo.disCode, 7'h7F);
    check("reset_hi", u_if_hi.disCode, 7'h00);
    step;
    check("reset_hold_lo", u_if_lo.disCode, 7'h7F);
    rst_n = 1'b1;
    step;
    check("first_lo", u_if_lo.disCode, 7'b0000000);
    check("first_hi", u_if_hi.disCode, 7'b1111111);

    // sweep all 16 codes
    for (int c = 0; c < 16; c++) begin
      drive(4'(c), 1'b0);
      step;
      check($sformatf("sweep_lo_%0h", c), u_if_lo.disCode, model(c, 1'b0, 1'b1));
      check($sformatf("sweep_hi_%0h", c), u_if_hi.disCode, model(c, 1'b0, 1'b0));
    end
    check("sweep_F_dark", u_if_lo.disCode, 7'h7F);

    // "FULL" lettering against reference values
    for (int k = 0; k < 4; k++) begin
      drive(full_code[k], 1'b0);
      step;
      check($sformatf("full_lo_%0d", k), u_if_lo.disCode, full_exp[k]);
      check($sformatf("full_hi_%0d", k), u_if_hi.disCode, ~full_exp[k]);
    end

    // blank override and release
    drive(4'h3, 1'b1);
    step;
    check("blank_lo", u_if_lo.disCode, 7'h7F);
    check("blank_hi", u_if_hi.disCode, 7'h00);
    drive(4'h3, 1'b0);
    step;
    check("unblank_lo", u_if_lo.disCode, 7'b0110000);
    check("unblank_hi", u_if_hi.disCode, 7'b1001111);

    // random codes and blank, changing every cycle
    for (int k = 0; k < 40; k++) begin
      rd = 4'($urandom_range(0, 15));
      rb = 1'($urandom_range(0, 3) == 0);
      drive(rd, rb);
      step;
      check($sformatf("rand_lo_%0d", k), u_if_lo.disCode, model(int'(rd), rb, 1'b1));
      check($sformatf("rand_hi_%0d", k), u_if_hi.disCode, model(int'(rd), rb, 1'b0));
    end

    // mid-run asynchronous reset
    drive(4'hD, 1'b0);
    step;
    check("dash_lo", u_if_lo.disCode, 7'b0111111);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_lo", u_if_lo.disCode, 7'h7F);
    check("midrst_hi", u_if_hi.disCode, 7'h00);
    #1 rst_n = 1'b1;
    step;
    check("midrst_rel_lo", u_if_lo.disCode, 7'b0111111);
    check("midrst_rel_hi", u_if_hi.disCode, 7'b1000000);

`ifdef ENCODER_BLINK_EN
    // blink: 4 cycles shown, 4 dark, counted from reset release
    drive(4'h1, 1'b0);
    drive_blink(1'b1);
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step;
      check($sformatf("blink_lo_%0d", k), u_if_lo.disCode, model(1, ((k / 4) % 2) == 1, 1'b1));
      check($sformatf("blink_hi_%0d", k), u_if_hi.disCode, model(1, ((k / 4) % 2) == 1, 1'b0));
    end
    drive_blink(1'b0);
    for (int k = 0; k < 8; k++) begin
      step;
      check($sformatf("noblink_lo_%0d", k), u_if_lo.disCode, 7'b1111001);
    end
    // blank wins over a visible blink phase
    drive(4'h1, 1'b1);
    drive_blink(1'b1);
    step;
    check("blank_over_blink", u_if_lo.disCode, 7'h7F);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
